dc_token_ring_fifo_dout_mram: RTL and testbench



---
 rtl/dc_fifo_mram_pkg.sv | 20 ++
 rtl/dc_token_ring_fifo_dout_mram_if.sv | 11 +
 rtl/dc_token_sync_mram.sv | 28 ++
 rtl/dc_token_ring_fifo_dout_mram.sv | 67 ++++++
 tb/tb_dc_token_ring_fifo_dout_mram.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/dc_fifo_mram_pkg.sv
// rtl/dc_fifo_mram_pkg.sv - token constants and pointer helper shared by both FIFO halves
package dc_fifo_mram_pkg;

  localparam int TOKEN_MAX = 64;
  localparam int SYNC_STAGES = 2;
  localparam logic [TOKEN_MAX-1:0] RESET_TOKEN = 64'hc;

  // Pointer bit i is set where token bits i and i-1 (circularly) are both set.
  function automatic logic [TOKEN_MAX-1:0] ptr_from_token(input logic [TOKEN_MAX-1:0] tok,
                                                          input int depth);
    logic [TOKEN_MAX-1:0] ptr;
    ptr = '0;
    ptr[0] = tok[0] & tok[depth-1];
    for (int i = 1; i < TOKEN_MAX; i++) begin
      if (i < depth) ptr[i] = tok[i] & tok[i-1];
    end
    return ptr;
  endfunction

endpackage

// File: rtl/dc_token_ring_fifo_dout_mram_if.sv
// rtl/dc_token_ring_fifo_dout_mram_if.sv - valid/ready output stream of the read-side FIFO half
interface dc_token_ring_fifo_dout_mram_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/dc_token_sync_mram.sv
// rtl/dc_token_sync_mram.sv - multi-flop synchronizer for the producer-domain write token
module dc_token_sync_mram
  import dc_fifo_mram_pkg::*;
#(
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [BUFFER_DEPTH-1:0] token_in,
  output logic [BUFFER_DEPTH-1:0] token_sync
);

  localparam logic [BUFFER_DEPTH-1:0] RST_TOK = RESET_TOKEN[BUFFER_DEPTH-1:0];

  logic [BUFFER_DEPTH-1:0] stage [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage[s] <= RST_TOK;
    end else begin
      stage[0] <= token_in;
      for (int s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
    end
  end

  assign token_sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/dc_token_ring_fifo_dout_mram.sv
// rtl/dc_token_ring_fifo_dout_mram.sv - consumer half of the dual-clock token-ring FIFO
module dc_token_ring_fifo_dout_mram
  import dc_fifo_mram_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  dc_token_ring_fifo_dout_mram_if.master dout,
  input  logic [BUFFER_DEPTH-1:0]   write_token,
  output logic [BUFFER_DEPTH-1:0]   read_pointer,
  input  logic [DATA_WIDTH-1:0]     data_async
);

  localparam logic [BUFFER_DEPTH-1:0] RST_TOK = RESET_TOKEN[BUFFER_DEPTH-1:0];

  logic [BUFFER_DEPTH-1:0] token_sync;
  logic [BUFFER_DEPTH-1:0] wr_ptr_sync;
  logic [BUFFER_DEPTH-1:0] read_token;
  logic [TOKEN_MAX-1:0]    wr_ptr_full;
  logic [TOKEN_MAX-1:0]    rd_ptr_full;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    valid_q;
  logic                    empty;
  logic                    pop;

  dc_token_sync_mram #(
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .token_in  (write_token),
    .token_sync(token_sync)
  );

  assign wr_ptr_full  = ptr_from_token(TOKEN_MAX'(token_sync), BUFFER_DEPTH);
  assign rd_ptr_full  = ptr_from_token(TOKEN_MAX'(read_token), BUFFER_DEPTH);
  assign wr_ptr_sync  = wr_ptr_full[BUFFER_DEPTH-1:0];
  assign read_pointer = rd_ptr_full[BUFFER_DEPTH-1:0];

  // Upper helper bits are constant zero for any legal depth.
  logic unused_ptr_hi;
  assign unused_ptr_hi = ^{wr_ptr_full[TOKEN_MAX-1:BUFFER_DEPTH], rd_ptr_full[TOKEN_MAX-1:BUFFER_DEPTH]};

  // Overlap instead of equality so a single glitched token bit reads as empty.
  assign empty = |(wr_ptr_sync & read_pointer);
  assign pop   = ~empty & (~valid_q | dout.ready);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      read_token <= RST_TOK;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else if (pop) begin
      read_token <= {read_token[BUFFER_DEPTH-2:0], read_token[BUFFER_DEPTH-1]};
      data_q     <= data_async;
      valid_q    <= 1'b1;
    end else if (valid_q && dout.ready) begin
      valid_q    <= 1'b0;
    end
  end

  assign dout.data  = data_q;
  assign dout.valid = valid_q;

endmodule

// File: tb/tb_dc_token_ring_fifo_dout_mram.sv
// tb/tb_dc_token_ring_fifo_dout_mram.sv - directed bench for the read-side FIFO half
module tb_dc_token_ring_fifo_dout_mram;

  localparam int DW = 10;
  localparam int BD = 8;

  logic          clk;
  logic          rstn;
  logic [BD-1:0] write_token;
  logic [BD-1:0] read_pointer;
  logic [DW-1:0] data_async;
  logic [DW-1:0] mem [BD];
  int            wr_idx;
  int            n_checks;
  int            n_pass;

  dc_token_ring_fifo_dout_mram_if #(.DATA_WIDTH(DW)) dout_if ();

  dc_token_ring_fifo_dout_mram #(
    .DATA_WIDTH  (DW),
    .BUFFER_DEPTH(BD)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .dout        (dout_if),
    .write_token (write_token),
    .read_pointer(read_pointer),
    .data_async  (data_async)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    data_async = '0;
    for (int i = 0; i < BD; i++) begin
      if (read_pointer[i]) data_async = mem[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Producer-side model: write the slot under the write pointer, then advance the token.
  task automatic push(input logic [DW-1:0] w);
    mem[wr_idx] = w;
    write_token = {write_token[BD-2:0], write_token[BD-1]};
    wr_idx = (wr_idx + 1) % BD;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    write_token = 8'h0c;
    wr_idx = 3;
    for (int k = 0; k < 3; k++) step();
    rstn = 1'b1;
  endtask

  logic [DW-1:0] words [9];
  logic [BD-1:0] exp_rp [9];

  initial begin
    int got_n;
    int pushed;
    n_checks = 0;
    n_pass = 0;
    dout_if.ready = 1'b0;
    for (int i = 0; i < BD; i++) mem[i] = '0;

    // reset state
    do_reset();
    check("rst_valid", 32'(dout_if.valid), 32'd0);
    check("rst_data", 32'(dout_if.data), 32'd0);
    check("rst_rp", 32'(read_pointer), 32'h08);
    for (int k = 0; k < 3; k++) step();
    check("idle_no_pop", 32'(dout_if.valid), 32'd0);

    // single word, latency 3 edges
    push(10'h2A3);
    step();
    step();
    check("lat_edge2_valid", 32'(dout_if.valid), 32'd0);
    step();
    check("single_valid", 32'(dout_if.valid), 32'd1);
    check("single_data", 32'(dout_if.data), 32'h2A3);
    check("single_rp", 32'(read_pointer), 32'h10);
    dout_if.ready = 1'b1;
    step();
    check("single_drain", 32'(dout_if.valid), 32'd0);

    // backpressure with three words
    dout_if.ready = 1'b0;
    push(10'h111);
    step();
    push(10'h222);
    step();
    push(10'h333);
    for (int k = 0; k < 5; k++) step();
    check("bp_valid", 32'(dout_if.valid), 32'd1);
    check("bp_data_hold", 32'(dout_if.data), 32'h111);
    check("bp_rp_once", 32'(read_pointer), 32'h20);
    step();
    check("bp_still_hold", 32'(dout_if.data), 32'h111);
    dout_if.ready = 1'b1;
    step();
    check("sim_pop_valid", 32'(dout_if.valid), 32'd1);
    check("sim_pop_data1", 32'(dout_if.data), 32'h222);
    check("sim_pop_rp", 32'(read_pointer), 32'h40);
    step();
    check("bp_data2", 32'(dout_if.data), 32'h333);
    check("bp_valid2", 32'(dout_if.valid), 32'd1);
    step();
    check("bp_drained", 32'(dout_if.valid), 32'd0);
    check("bp_rp_end", 32'(read_pointer), 32'h80);

    // wrap-around from reset, nine words streamed
    dout_if.ready = 1'b0;
    do_reset();
    exp_rp[0] = 8'h10; exp_rp[1] = 8'h20; exp_rp[2] = 8'h40; exp_rp[3] = 8'h80;
    exp_rp[4] = 8'h01; exp_rp[5] = 8'h02; exp_rp[6] = 8'h04; exp_rp[7] = 8'h08;
    exp_rp[8] = 8'h10;
    for (int i = 0; i < 9; i++) words[i] = DW'(10'h100 + i * 37);
    dout_if.ready = 1'b1;
    got_n = 0;
    pushed = 0;
    for (int cyc = 0; cyc < 40 && got_n < 9; cyc++) begin
      if (pushed < 9) begin
        push(words[pushed]);
        pushed++;
      end
      step();
      if (dout_if.valid) begin
        check($sformatf("wrap_data%0d", got_n), 32'(dout_if.data), 32'(words[got_n]));
        check($sformatf("wrap_rp%0d", got_n), 32'(read_pointer), 32'(exp_rp[got_n]));
        got_n++;
      end
    end
    check("wrap_count", 32'(got_n), 32'd9);
    step();
    check("wrap_no_dup", 32'(dout_if.valid), 32'd0);

    // reset mid-stream with two words buffered
    dout_if.ready = 1'b0;
    push(10'h3C5);
    step();
    push(10'h05A);
    for (int k = 0; k < 5; k++) step();
    check("mid_pre_valid", 32'(dout_if.valid), 32'd1);
    rstn = 1'b0;
    write_token = 8'h0c;
    wr_idx = 3;
    step();
    check("mid_rst_valid", 32'(dout_if.valid), 32'd0);
    check("mid_rst_rp", 32'(read_pointer), 32'h08);
    rstn = 1'b1;
    dout_if.ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("mid_no_stale%0d", k), 32'(dout_if.valid), 32'd0);
    end
    check("mid_rp_idle", 32'(read_pointer), 32'h08);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
